// File: rtl/tick_period_monitor.sv
// ---------------------------------------------------------------------------
// tick_period_monitor
//
// Measures the edge-to-edge (half-period) interval of a slow square wave in
// clk cycles, checks each interval against NUM +/- TOL, and reports lock
// after LOCK_N consecutive in-tolerance intervals. If no edge arrives for
// TIMEOUT cycles the monitor enters FAULT until the next edge.
//
// Build option:
//   TICK_PERIOD_MONITOR_SYNC2_EN  defined   -> two-flop synchronizer on
//                                              'signal' (asynchronous input)
//                                 undefined -> single sampling flop (input
//                                              already synchronous to clk),
//                                              one cycle less edge latency
//
// Parameters:
//   NUM      expected half-period in clk cycles
//   TOL      allowed deviation from NUM in clk cycles
//   LOCK_N   consecutive matches required for lock (1..15)
//   TIMEOUT  cycles without an edge before FAULT (must exceed NUM+TOL)
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   signal        in   square wave under test
//   rise_pulse    out  one-cycle pulse per synchronized rising edge
//   fall_pulse    out  one-cycle pulse per synchronized falling edge
//   half_period   out  last measured edge-to-edge interval (clk cycles)
//   period_valid  out  one-cycle strobe when half_period updates
//   locked        out  LOCK_N consecutive in-tolerance intervals seen
//   fault         out  high while in FAULT
// ---------------------------------------------------------------------------
module tick_period_monitor #(
  parameter int unsigned NUM     = 250000,
  parameter int unsigned TOL     = 16,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        signal,
  output logic        rise_pulse,
  output logic        fall_pulse,
  output logic [31:0] half_period,
  output logic        period_valid,
  output logic        locked,
  output logic        fault
);

  // Tolerance window in 33 bits so NUM+TOL cannot overflow.
  localparam logic [32:0] WIN_LO  = (TOL > NUM) ? 33'd0 : (33'(NUM) - 33'(TOL));
  localparam logic [32:0] WIN_HI  = 33'(NUM) + 33'(TOL);
  localparam logic [31:0] CNT_TMO = 32'(TIMEOUT);
  localparam logic [3:0]  GOOD_MAX = 4'(LOCK_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_FAULT
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronization and edge detection
  // -------------------------------------------------------------------------
  logic r_sync;
  logic r_dly;

`ifdef TICK_PERIOD_MONITOR_SYNC2_EN
  logic r_meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= signal;
      r_sync <= r_meta;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= signal;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dly <= 1'b0;
    end else begin
      r_dly <= r_sync;
    end
  end

  logic w_edge;
  logic w_level;

  // Flops reset to 0, so a signal already high at release shows up as one
  // rising edge, which the FSM takes as its first reference edge.
  assign w_edge  = r_sync ^ r_dly;
  assign w_level = r_sync;

  // -------------------------------------------------------------------------
  // Interval match
  // -------------------------------------------------------------------------
  logic [31:0] r_cnt;
  logic [32:0] w_cnt_ext;
  logic        w_lo_ok;
  logic        w_hi_ok;
  logic        w_match;

  assign w_cnt_ext = {1'b0, r_cnt};

  // Lower bound clamps at 0 when TOL >= NUM; resolved at elaboration so the
  // trivially-true compare is never built.
  if (TOL >= NUM) begin : g_lo_clamped
    assign w_lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign w_lo_ok = (w_cnt_ext >= WIN_LO);
  end

  assign w_hi_ok = (w_cnt_ext <= WIN_HI);
  assign w_match = w_lo_ok & w_hi_ok;

  // -------------------------------------------------------------------------
  // FSM: state and datapath registers
  // -------------------------------------------------------------------------
  state_t      r_state;
  logic [3:0]  r_good;
  logic [31:0] r_half;
  logic        r_pv;
  logic        r_locked;
  logic        r_fault;
  logic        r_rise;
  logic        r_fall;

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic [3:0]  w_good_nxt;
  logic [31:0] w_half_nxt;
  logic        w_pv_nxt;
  logic        w_locked_nxt;
  logic        w_fault_nxt;
  logic        w_rise_nxt;
  logic        w_fall_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_good   <= '0;
      r_half   <= '0;
      r_pv     <= 1'b0;
      r_locked <= 1'b0;
      r_fault  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_good   <= w_good_nxt;
      r_half   <= w_half_nxt;
      r_pv     <= w_pv_nxt;
      r_locked <= w_locked_nxt;
      r_fault  <= w_fault_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_good_nxt  = r_good;
    w_half_nxt  = r_half;
    w_pv_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_edge) begin
          // First edge is only a reference; nothing to measure yet.
          w_state_nxt = S_MEASURE;
          w_cnt_nxt   = 32'd1;
        end
      end

      S_MEASURE: begin
        // Edge takes priority over timeout in the same cycle.
        if (w_edge) begin
          w_half_nxt = r_cnt;
          w_pv_nxt   = 1'b1;
          w_cnt_nxt  = 32'd1;
          if (w_match) begin
            w_good_nxt = (r_good == GOOD_MAX) ? r_good : (r_good + 4'd1);
          end else begin
            w_good_nxt = '0;
          end
        end else if (r_cnt >= CNT_TMO) begin
          w_state_nxt = S_FAULT;
          w_good_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_FAULT: begin
        // Count frozen; the recovering edge restarts measurement without
        // producing a strobe.
        if (w_edge) begin
          w_state_nxt = S_MEASURE;
          w_cnt_nxt   = 32'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_good_nxt  = '0;
      end
    endcase

    w_locked_nxt = (w_good_nxt == GOOD_MAX);
    w_fault_nxt  = (w_state_nxt == S_FAULT);
    w_rise_nxt   = w_edge & w_level;
    w_fall_nxt   = w_edge & ~w_level;
  end

  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign half_period  = r_half;
  assign period_valid = r_pv;
  assign locked       = r_locked;
  assign fault        = r_fault;

endmodule

// File: tb/tb_tick_period_monitor.sv
module tb_tick_period_monitor;

  localparam int unsigned NUM     = 10;
  localparam int unsigned TOL     = 1;
  localparam int unsigned LOCK_N  = 3;
  localparam int unsigned TIMEOUT = 40;

`ifdef TICK_PERIOD_MONITOR_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        signal;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [31:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        fault;

  int total = 0;
  int bad   = 0;

  tick_period_monitor #(
    .NUM(NUM),
    .TOL(TOL),
    .LOCK_N(LOCK_N),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .signal(signal),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .half_period(half_period),
    .period_valid(period_valid),
    .locked(locked),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Cycle counter, expected-result queue and observed-strobe queue.
  int unsigned cyc = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  int          rise_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (period_valid) obs_q.push_back({locked, half_period});
    if (rise_pulse) rise_cnt++;
  end

  // Reference model state.
  bit          m_ref  = 0;
  int unsigned m_good = 0;
  int unsigned last_tog = 0;

  // Toggle the input just after a posedge and predict the resulting strobe.
  task automatic toggle();
    int unsigned iv;
    iv = cyc - last_tog;
    if (m_ref && iv <= TIMEOUT) begin
      if (iv >= NUM - TOL && iv <= NUM + TOL)
        m_good = (m_good == LOCK_N) ? m_good : m_good + 1;
      else
        m_good = 0;
      exp_q.push_back({(m_good == LOCK_N), iv});
    end else begin
      m_good = 0;
    end
    m_ref    = 1;
    last_tog = cyc;
    signal   = ~signal;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ref  = 0;
    m_good = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    signal = 1'b1;
    wait_cyc(3);
    total++; if (rise_pulse !== 1'b0)   begin bad++; $display("FAIL rst_rise got=%b exp=0", rise_pulse); end
    total++; if (fall_pulse !== 1'b0)   begin bad++; $display("FAIL rst_fall got=%b exp=0", fall_pulse); end
    total++; if (half_period !== 32'd0) begin bad++; $display("FAIL rst_half got=%0d exp=0", half_period); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL rst_pv got=%b exp=0", period_valid); end
    total++; if (locked !== 1'b0)       begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
    total++; if (fault !== 1'b0)        begin bad++; $display("FAIL rst_fault got=%b exp=0", fault); end
    // Signal high at release: exactly one rise pulse, no strobe.
    rise_cnt = 0;
    obs_q.delete();
    reset = 1'b0;
    wait_cyc(8);
    total++; if (rise_cnt !== 1) begin bad++; $display("FAIL rst_high_rise got=%0d exp=1", rise_cnt); end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL rst_high_nostrobe got=%0d exp=0", obs_q.size()); end
    reset  = 1'b1;
    signal = 1'b0;
    wait_cyc(2);
    reset = 1'b0;
    model_reset();
    wait_cyc(1);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 5; i++) begin
      toggle();
      wait_cyc(10);
    end
    total++; if (exp_q.size() !== 4) begin bad++; $display("FAIL lock_exp_count got=%0d exp=4", exp_q.size()); end
    while (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL lock_missing exp=%h", e); end
      else begin
        logic [32:0] o;
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL lock_strobe got=%h exp=%h", o, e); end
      end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL lock_extra got=%0d exp=0", obs_q.size()); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked got=%b exp=1", locked); end
  endtask

  task automatic test_unlock();
    wait_cyc(3);
    toggle();
    for (int i = 0; i < 3; i++) begin
      wait_cyc(10);
      toggle();
    end
    wait_cyc(10);
    while (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL unlock_missing exp=%h", e); end
      else begin
        logic [32:0] o;
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL unlock_strobe got=%h exp=%h", o, e); end
      end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL unlock_extra got=%0d exp=0", obs_q.size()); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL unlock_relock got=%b exp=1", locked); end
  endtask

  task automatic test_fault();
    wait_cyc(35);
    total++; if (fault !== 1'b1)  begin bad++; $display("FAIL fault_set got=%b exp=1", fault); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL fault_locked got=%b exp=0", locked); end
    toggle();
    wait_cyc(10);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", fault); end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL fault_nostrobe got=%0d exp=0", obs_q.size()); end
    toggle();
    wait_cyc(10);
    while (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL fault_missing exp=%h", e); end
      else begin
        logic [32:0] o;
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL fault_strobe got=%h exp=%h", o, e); end
      end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL fault_extra got=%0d exp=0", obs_q.size()); end
  endtask

  task automatic test_tolerance();
    int iv_tab[5] = '{9, 11, 12, 10, 40};
    foreach (iv_tab[i]) begin
      wait_cyc(iv_tab[i] - 10);
      toggle();
      wait_cyc(10);
    end
    while (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL tol_missing exp=%h", e); end
      else begin
        logic [32:0] o;
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL tol_strobe got=%h exp=%h", o, e); end
      end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL tol_extra got=%0d exp=0", obs_q.size()); end
    // Interval of exactly TIMEOUT was measured, not faulted.
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL tol_tmo_edge got=%b exp=0", fault); end
  endtask

  task automatic test_latency();
    int k;
    bit seen;
    wait_cyc(35);
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL lat_pre_fault got=%b exp=1", fault); end
    toggle();
    k    = 0;
    seen = 0;
    while (!seen && k < 10) begin
      wait_cyc(1);
      k++;
      if (rise_pulse || fall_pulse) seen = 1;
    end
    total++; if (k !== LAT) begin bad++; $display("FAIL lat_cycles got=%0d exp=%0d", k, LAT); end
    wait_cyc(1);
    total++; if ((rise_pulse | fall_pulse) !== 1'b0) begin bad++; $display("FAIL lat_width got=%b exp=0", rise_pulse | fall_pulse); end
    wait_cyc(10 - k - 1);
    toggle();
    wait_cyc(10);
    while (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL lat_missing exp=%h", e); end
      else begin
        logic [32:0] o;
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL lat_strobe got=%h exp=%h", o, e); end
      end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL lat_extra got=%0d exp=0", obs_q.size()); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      toggle();
      wait_cyc(10);
    end
    exp_q.delete();
    obs_q.delete();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL ar_prelock got=%b exp=1", locked); end
    wait_cyc(4);
    #2;
    reset = 1'b1;
    #1;
    total++; if (locked !== 1'b0)       begin bad++; $display("FAIL ar_locked got=%b exp=0", locked); end
    total++; if (half_period !== 32'd0) begin bad++; $display("FAIL ar_half got=%0d exp=0", half_period); end
    total++; if (fault !== 1'b0)        begin bad++; $display("FAIL ar_fault got=%b exp=0", fault); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL ar_pv got=%b exp=0", period_valid); end
    signal = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    model_reset();
    wait_cyc(1);
    toggle();
    wait_cyc(10);
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL ar_first_nostrobe got=%0d exp=0", obs_q.size()); end
    toggle();
    wait_cyc(10);
    while (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL ar_missing exp=%h", e); end
      else begin
        logic [32:0] o;
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL ar_strobe got=%h exp=%h", o, e); end
      end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL ar_extra got=%0d exp=0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_unlock();
    test_fault();
    test_tolerance();
    test_latency();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
